ddr_pattern_tx: RTL and testbench
=================================

Name: ddr_pattern_tx

Overview:
- Parametrised multi-channel DDR pattern serialiser that feeds ODDR/TLVDS_OBUF pairs, one pair per channel.
- Accepts parallel words through a valid/ready handshake and emits two bits per channel on each prescaler tick (D0/D1 for the ODDR).
- Adds a runtime clock divider, double buffering, an ODDR warm-up guard, and a programmable idle pattern.
- Sits between user logic and the per-channel ODDR + TLVDS_OBUF instances in the top level.

Parameters:
- CHANNELS, 2, number of independent DDR lanes.
- WORD_W, 8, bits per channel per word; must be even and ≥2.
- DIV_W, 25, width of the prescaler counter and of the div input.
- WARMUP_TICKS, 4, ticks of idle output after reset before data may be shifted (ODDR start-up).
- IDLE_D0, 1'b0, D0 value driven while idle or warming up.
- IDLE_D1, 1'b1, D1 value driven while idle or warming up; the defaults give a toggling line.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- div  in  DIV_W  tick period minus one; 0 means a tick every clk.
- in_valid  in  1  word available.
- in_ready  out  1  holding buffer empty.
- in_data  in  CHANNELS*WORD_W  channel c occupies bits [c*WORD_W +: WORD_W].
- ddr_d0  out  CHANNELS  per-lane D0 to the ODDR.
- ddr_d1  out  CHANNELS  per-lane D1 to the ODDR.
- tick  out  1  one-cycle strobe on each prescaler tick; also used as the ODDR clock enable.
- busy  out  1  shifter holds an active word.
- word_done  out  1  one-cycle pulse when the last pair of a word is emitted.
- underrun  out  1  one-cycle pulse on SHIFT→IDLE with the holding buffer empty.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - prescaler count=0, state=WARMUP, warm-up count=0.
  - hold empty, in_ready=0, ddr_d0/ddr_d1 = all IDLE_D0/IDLE_D1.
  - tick=busy=word_done=underrun=0.
  - Any in-flight or held word is discarded.
  - Reset applied mid-word restarts warm-up.
- Prescaler:
  - count increments each clk.
  - When count>=div, tick=1 that cycle and count←0. The >= comparison makes lowering div mid-run safe: the next cycle ticks.
- in_ready = hold empty AND state!=WARMUP, from registered state only.
- Accept on in_valid&&in_ready: hold←in_data and hold becomes full. No accept and move can occur in the same cycle because in_ready is low while hold is full.
- State machine; transitions and outputs update only on tick cycles unless noted:
  - WARMUP:
    - drive the idle pair; warm-up count++ per tick.
    - after WARMUP_TICKS ticks → IDLE.
  - IDLE:
    - drive the idle pair.
    - on a tick with hold full: shifter←hold, hold empties, outputs←pair 0 (ddr_d0[c]=word_c[0], ddr_d1[c]=word_c[1]), pair count=1, → SHIFT.
  - SHIFT, on each tick:
    - if pair count<WORD_W/2: emit pair k (bits [2k], [2k+1], LSB first) and increment pair count.
    - else (last pair already emitted): word_done pulses, then:
      - if hold is full, load it and emit its pair 0 on this same tick, giving gapless back-to-back words;
      - otherwise drive the idle pair, pulse underrun, → IDLE.
- Latency:
  - In IDLE, the first pair appears on ddr_d0/d1 the cycle after the first tick following acceptance.
  - The word occupies exactly WORD_W/2 ticks on the line.
- All channels shift in lockstep; one handshake covers all lanes.
- busy=1 in SHIFT, 0 otherwise.
- ddr_d0/ddr_d1 are registered and stable between ticks.

Decomposition:
- Package ddr_tx_pkg holds:
  - the state enum (WARMUP, IDLE, SHIFT);
  - the helper constant PAIRS = WORD_W/2;
  - the pair count width function clog2(PAIRS+1).
- Sub-module ddr_tick_gen (DIV_W) holds the prescaler: inputs clk, rst_n, div; output tick.
- The top-level ddr_pattern_tx instantiates ddr_tick_gen plus the per-lane shift registers via a generate loop. ODDR/TLVDS_OBUF remain outside in the board top.

Test Plan:
- Reset, div=3: idle pair (0,1) on all lanes; tick every 4 clk; in_ready rises only after 4 ticks (cycle 16 after reset release).
- CHANNELS=2, WORD_W=8, div=0, ch0=8'hB2, ch1=8'h0F: ch0 pairs (d0,d1)=(0,1),(0,0),(1,1),(0,1); ch1 pairs (1,1),(1,1),(0,0),(0,0); word_done on the 4th pair; then underrun and idle (0,1).
- Two words back-to-back with the second accepted during the first: 8 consecutive pairs with no idle gap; word_done pulses twice; no underrun.
- div changed from 100 to 2 while count=50: tick on the next cycle, then every 3 clk; no lost or duplicated pair.
- rst_n low for 1 clk during pair 2 of a word: outputs return to idle the next cycle; the held word is discarded; full warm-up repeats; in_ready stays 0 throughout warm-up.
- in_valid held high while hold is full: in_ready=0, no overwrite; the data accepted equals the value present on the cycle in_ready returns to 1.

Source files
------------

// File: rtl/ddr_tx_pkg.sv
// Shared types and sizing helpers for the DDR pattern serialiser.
package ddr_tx_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SHIFT  = 2'd2
    } tx_state_e;

    function automatic int pairs_of(input int word_w);
        return word_w / 2;
    endfunction

    function automatic int pair_cnt_w(input int word_w);
        return $clog2(word_w / 2 + 1);
    endfunction

endpackage

// File: rtl/ddr_tick_gen.sv
// Runtime-programmable prescaler producing a one-cycle tick every div+1 clocks.
module ddr_tick_gen #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;

    // Count up and wrap; >= rather than == so lowering div mid-count ticks at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r >= div) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + DIV_W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ddr_pattern_tx.sv
// Multi-lane DDR pattern serialiser: double-buffered words go out two bits per
// lane per tick to external ODDR primitives, with warm-up and idle patterns.
module ddr_pattern_tx
    import ddr_tx_pkg::*;
#(
    parameter int   CHANNELS     = 2,
    parameter int   WORD_W       = 8,
    parameter int   DIV_W        = 25,
    parameter int   WARMUP_TICKS = 4,
    parameter logic IDLE_D0      = 1'b0,
    parameter logic IDLE_D1      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIV_W-1:0]           div,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*WORD_W-1:0] in_data,
    output logic [CHANNELS-1:0]        ddr_d0,
    output logic [CHANNELS-1:0]        ddr_d1,
    output logic                       tick,
    output logic                       busy,
    output logic                       word_done,
    output logic                       underrun
);

    localparam int PAIRS = pairs_of(WORD_W);
    localparam int PCW   = pair_cnt_w(WORD_W);
    localparam int WCW   = (WARMUP_TICKS > 0) ? $clog2(WARMUP_TICKS + 1) : 1;
    localparam logic [WCW-1:0] WARM_LAST = (WARMUP_TICKS > 0) ? WCW'(WARMUP_TICKS - 1) : '0;

    tx_state_e                 state_r;
    logic [WCW-1:0]            warm_cnt_r;
    logic [PCW-1:0]            pair_cnt_r;
    logic [CHANNELS*WORD_W-1:0] hold_r;
    logic                      hold_full_r;
    logic                      busy_r;
    logic                      word_done_r;
    logic                      underrun_r;

    logic                      tick_s;
    logic                      in_ready_s;
    logic                      load_s;
    logic                      shift_s;
    logic                      idle_s;
    logic                      last_s;

    ddr_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div),
        .tick  (tick_s)
    );

    assign in_ready_s = !hold_full_r && (state_r != ST_WARMUP);

    // Per-tick datapath command decode shared by all lanes.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        idle_s  = 1'b0;
        last_s  = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_WARMUP: idle_s = 1'b1;
                ST_IDLE: begin
                    if (hold_full_r) begin
                        load_s = 1'b1;
                    end else begin
                        idle_s = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (pair_cnt_r < PCW'(PAIRS)) begin
                        shift_s = 1'b1;
                    end else begin
                        last_s = 1'b1;
                        if (hold_full_r) begin
                            load_s = 1'b1;
                        end else begin
                            idle_s = 1'b1;
                        end
                    end
                end
                default: idle_s = 1'b1;
            endcase
        end else begin
            load_s  = 1'b0;
            shift_s = 1'b0;
        end
    end

    // Control FSM, holding buffer and status strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_WARMUP;
            warm_cnt_r  <= '0;
            pair_cnt_r  <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            busy_r      <= 1'b0;
            word_done_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            word_done_r <= last_s;
            underrun_r  <= last_s && !hold_full_r;

            // Accept and load never coincide: in_ready is low while the hold is full.
            if (load_s) begin
                hold_full_r <= 1'b0;
            end else if (in_valid && in_ready_s) begin
                hold_r      <= in_data;
                hold_full_r <= 1'b1;
            end

            if (tick_s) begin
                case (state_r)
                    ST_WARMUP: begin
                        if (warm_cnt_r >= WARM_LAST) begin
                            state_r    <= ST_IDLE;
                            warm_cnt_r <= '0;
                        end else begin
                            warm_cnt_r <= warm_cnt_r + WCW'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (hold_full_r) begin
                            state_r    <= ST_SHIFT;
                            pair_cnt_r <= PCW'(1);
                            busy_r     <= 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (pair_cnt_r < PCW'(PAIRS)) begin
                            pair_cnt_r <= pair_cnt_r + PCW'(1);
                        end else if (hold_full_r) begin
                            pair_cnt_r <= PCW'(1);
                        end else begin
                            state_r    <= ST_IDLE;
                            pair_cnt_r <= '0;
                            busy_r     <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= ST_WARMUP;
                        warm_cnt_r <= '0;
                        pair_cnt_r <= '0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [WORD_W-1:0] word_s;
        logic [WORD_W-1:0] sh_r;
        logic              d0_r;
        logic              d1_r;

        assign word_s = hold_r[c*WORD_W +: WORD_W];

        // Lane shifter: pair 0 comes straight from the hold, later pairs LSB-first.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sh_r <= '0;
                d0_r <= IDLE_D0;
                d1_r <= IDLE_D1;
            end else if (load_s) begin
                sh_r <= word_s >> 2'd2;
                d0_r <= word_s[0];
                d1_r <= word_s[1];
            end else if (shift_s) begin
                sh_r <= sh_r >> 2'd2;
                d0_r <= sh_r[0];
                d1_r <= sh_r[1];
            end else if (idle_s) begin
                d0_r <= IDLE_D0;
                d1_r <= IDLE_D1;
            end
        end

        assign ddr_d0[c] = d0_r;
        assign ddr_d1[c] = d1_r;
    end

    assign in_ready  = in_ready_s;
    assign tick      = tick_s;
    assign busy      = busy_r;
    assign word_done = word_done_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_ddr_pattern_tx.sv
// Self-checking bench for ddr_pattern_tx: vector table plus scoreboard of expected pairs.
module tb_ddr_pattern_tx;

    localparam int CH = 2;
    localparam int WW = 8;
    localparam int DW = 25;
    localparam int NP = WW / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    div;
    logic             in_valid;
    logic             in_ready;
    logic [CH*WW-1:0] in_data;
    logic [CH-1:0]    ddr_d0;
    logic [CH-1:0]    ddr_d1;
    logic             tick;
    logic             busy;
    logic             word_done;
    logic             underrun;

    ddr_pattern_tx #(
        .CHANNELS(CH), .WORD_W(WW), .DIV_W(DW), .WARMUP_TICKS(4),
        .IDLE_D0(1'b0), .IDLE_D1(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .div(div), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ddr_d0(ddr_d0), .ddr_d1(ddr_d1), .tick(tick), .busy(busy),
        .word_done(word_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] d0;
        logic [CH-1:0] d1;
    } pair_t;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp_d0;
        logic [7:0]  exp_d1;
    } vec_t;

    pair_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_wd    = 0;
    int    n_ur    = 0;
    int    n_pop   = 0;
    bit    gap_seen  = 1'b0;
    bit    prev_tick = 1'b0;
    bit    prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic pair_t model_pair(input logic [15:0] w, input int p);
        pair_t e;
        for (int c = 0; c < CH; c++) begin
            e.d0[c] = w[c*WW + 2*p];
            e.d1[c] = w[c*WW + 2*p + 1];
        end
        return e;
    endfunction

    // Monitor: after every tick, compare the new line values with the scoreboard.
    always @(negedge clk) begin : mon
        pair_t e;
        if (rst_n === 1'b1) begin
            if (word_done === 1'b1) n_wd++;
            if (underrun === 1'b1) n_ur++;
            if (prev_tick) begin
                if (busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_pair: got d0=%b d1=%b with empty scoreboard", ddr_d0, ddr_d1);
                    end else begin
                        e = exp_q.pop_front();
                        check("pair_d0", ddr_d0, e.d0);
                        check("pair_d1", ddr_d1, e.d1);
                        n_pop++;
                    end
                end else begin
                    check("idle_d0", ddr_d0, 2'b00);
                    check("idle_d1", ddr_d1, 2'b11);
                end
            end
            if (prev_busy && (busy === 1'b0) && (exp_q.size() != 0)) gap_seen = 1'b1;
        end
        prev_tick = (tick === 1'b1);
        prev_busy = (busy === 1'b1);
    end

    task automatic push_word(input logic [15:0] w);
        for (int p = 0; p < NP; p++) exp_q.push_back(model_pair(w, p));
    endtask

    task automatic send_word(input logic [15:0] data, input logic [7:0] ed0, input logic [7:0] ed1);
        pair_t e;
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 1000) begin
            step();
            g++;
        end
        if (in_ready !== 1'b1) begin
            timeout("send_wait_ready");
        end else begin
            in_valid = 1'b1;
            in_data  = data;
            for (int p = 0; p < NP; p++) begin
                e.d0 = ed0[2*p +: 2];
                e.d1 = ed1[2*p +: 2];
                exp_q.push_back(e);
            end
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int limit);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && g < limit) begin
            step();
            g++;
        end
        if (exp_q.size() != 0 || busy !== 1'b0) timeout("drain");
        step();
        step();
    endtask

    // Warm-up: in_ready must stay low until the 4th tick has been seen, then rise.
    task automatic warmup_check(input int period);
        int  ticks;
        bit  done;
        ticks = 0;
        done  = 1'b0;
        for (int i = 1; i <= 400 && !done; i++) begin
            step();
            if (ticks == 4) begin
                check("in_ready_after_warmup", in_ready, 1'b1);
                done = 1'b1;
            end else begin
                check("in_ready_warmup", in_ready, 1'b0);
                check("tick_period", tick, (i % period) == 0);
                if (tick === 1'b1) ticks++;
            end
        end
        if (!done) timeout("warmup");
    endtask

    task automatic stream_held(input int n);
        int got;
        int blocked;
        int guard;
        got = 0;
        blocked = 0;
        guard = 0;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        while (got < n && guard < 2000) begin
            if (in_ready === 1'b1) begin
                push_word(in_data);
                got++;
            end else begin
                blocked++;
            end
            step();
            in_data = 16'($urandom);
            guard++;
        end
        in_valid = 1'b0;
        check("stream_accepted", got, n);
        check("stream_blocked_seen", blocked > 0, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vt [4];
        int   wd0;
        int   ur0;
        int   pop0;
        int   g;
        int   busy_cnt;

        vt[0] = '{16'h0FB2, 8'h1A, 8'h5B};
        vt[1] = '{16'hFF00, 8'hAA, 8'hAA};
        vt[2] = '{16'h55AA, 8'hAA, 8'h55};
        vt[3] = '{16'h1E3C, 8'h3C, 8'h1E};

        rst_n    = 1'b0;
        div      = DW'(3);
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) step();
        check("reset_d0", ddr_d0, 2'b00);
        check("reset_d1", ddr_d1, 2'b11);
        check("reset_flags", {in_ready, tick, busy, word_done, underrun}, 5'b00000);

        rst_n = 1'b1;
        warmup_check(4);

        // Table: single words, each followed by word_done and underrun.
        div = DW'(0);
        for (int v = 0; v < 4; v++) begin
            wd0 = n_wd;
            ur0 = n_ur;
            send_word(vt[v].data, vt[v].exp_d0, vt[v].exp_d1);
            wait_drain(200);
            check("word_done_count", n_wd - wd0, 1);
            check("underrun_count", n_ur - ur0, 1);
        end

        // Back-to-back: second word accepted while the first is on the line.
        wd0 = n_wd;
        ur0 = n_ur;
        gap_seen = 1'b0;
        send_word(vt[0].data, vt[0].exp_d0, vt[0].exp_d1);
        send_word(vt[3].data, vt[3].exp_d0, vt[3].exp_d1);
        wait_drain(200);
        check("b2b_word_done", n_wd - wd0, 2);
        check("b2b_underrun", n_ur - ur0, 1);
        check("b2b_gap", gap_seen, 1'b0);

        // in_valid held high while the hold is full: only presented-on-ready data is taken.
        gap_seen = 1'b0;
        stream_held(3);
        wait_drain(300);
        check("stream_gap", gap_seen, 1'b0);

        // Lower div from 100 to 2 while the prescaler is at 50.
        div = DW'(100);
        wd0 = n_wd;
        send_word(vt[2].data, vt[2].exp_d0, vt[2].exp_d1);
        g = 0;
        while (busy !== 1'b1 && g < 400) begin step(); g++; end
        if (busy !== 1'b1) timeout("div_busy");
        g = 0;
        while (tick !== 1'b1 && g < 400) begin step(); g++; end
        if (tick !== 1'b1) timeout("div_tick");
        repeat (50) step();
        div = DW'(2);
        step();
        check("div_drop_tick_next", tick, 1'b1);
        step();
        check("div_drop_gap1", tick, 1'b0);
        step();
        check("div_drop_gap2", tick, 1'b0);
        step();
        check("div_drop_period3", tick, 1'b1);
        wait_drain(400);
        check("div_word_done", n_wd - wd0, 1);

        // Reset for one clock mid-word with a second word held.
        div  = DW'(0);
        pop0 = n_pop;
        send_word(vt[1].data, vt[1].exp_d0, vt[1].exp_d1);
        send_word(vt[3].data, vt[3].exp_d0, vt[3].exp_d1);
        g = 0;
        while (n_pop < pop0 + 2 && g < 100) begin step(); g++; end
        if (n_pop < pop0 + 2) timeout("midword_pairs");
        check("midword_busy", busy, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        check("rst_mid_d0", ddr_d0, 2'b00);
        check("rst_mid_d1", ddr_d1, 2'b11);
        check("rst_mid_flags", {in_ready, busy}, 2'b00);
        warmup_check(1);
        pop0 = n_pop;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        check("held_word_discarded", busy_cnt, 0);
        check("no_pairs_after_reset", n_pop - pop0, 0);

        // Fresh word after the reset still serialises correctly.
        send_word(vt[3].data, vt[3].exp_d0, vt[3].exp_d1);
        wait_drain(200);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
